// File: rtl/oled_frame_sequencer.sv
// SSD1306 panel sequencer: hardware reset pulse, fixed init command stream, then
// full-frame page/column streaming, handshaking one byte at a time with spiMaster.
module oled_frame_sequencer #(
  parameter int unsigned RST_CYCLES = 1_000_000,
  parameter int unsigned PAGES      = 8,
  parameter int unsigned COLS       = 128
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_req,
  output logic [9:0] fb_addr,
  input  logic [7:0] fb_data,
  input  logic       spi_send_done,
  output logic [7:0] spi_data_out,
  output logic       dc_in,
  output logic       spi_send,
  output logic       oled_res_n,
  output logic       init_done,
  output logic       busy
);

  localparam int unsigned CNT_W    = $clog2(RST_CYCLES + 1);
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned COL_W    = 7;
  localparam int unsigned PG_W     = 3;
  localparam int unsigned INIT_LEN = 25;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_FRAME
  } top_e;

  typedef enum logic [1:0] {
    B_ADDR,
    B_LOAD,
    B_SEND,
    B_DRAIN
  } byte_e;

  top_e             top_q, top_d;
  byte_e            sub_q, sub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [PG_W-1:0]  page_q, page_d;
  logic             data_ph_q, data_ph_d;
  logic             pending_q, pending_d;
  logic             done_sync_q, done_sync_d;
  logic             done_prev_q, done_prev_d;
  logic             spi_send_q, spi_send_d;
  logic [7:0]       spi_data_q, spi_data_d;
  logic             dc_q, dc_d;
  logic             oled_res_n_q, oled_res_n_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;
  logic [9:0]       fb_addr_q, fb_addr_d;
  logic             done_rise_c;
  logic [7:0]       page_cmd_c;

  // SSD1306 power-up command list
  function automatic logic [7:0] init_rom(input logic [IDX_W-1:0] i);
    case (i)
      5'd0:    return 8'hAE;
      5'd1:    return 8'hD5;
      5'd2:    return 8'h80;
      5'd3:    return 8'hA8;
      5'd4:    return 8'h3F;
      5'd5:    return 8'hD3;
      5'd6:    return 8'h00;
      5'd7:    return 8'h40;
      5'd8:    return 8'h8D;
      5'd9:    return 8'h14;
      5'd10:   return 8'h20;
      5'd11:   return 8'h02;
      5'd12:   return 8'hA1;
      5'd13:   return 8'hC8;
      5'd14:   return 8'hDA;
      5'd15:   return 8'h12;
      5'd16:   return 8'h81;
      5'd17:   return 8'hCF;
      5'd18:   return 8'hD9;
      5'd19:   return 8'hF1;
      5'd20:   return 8'hDB;
      5'd21:   return 8'h40;
      5'd22:   return 8'hA4;
      5'd23:   return 8'hA6;
      5'd24:   return 8'hAF;
      default: return 8'h00;
    endcase
  endfunction

  assign done_rise_c = done_sync_q & ~done_prev_q;

  always_comb begin
    case (idx_q[1:0])
      2'd0:    page_cmd_c = 8'hB0 + 8'(page_q);
      2'd1:    page_cmd_c = 8'h00;
      default: page_cmd_c = 8'h10;
    endcase
  end

  always_comb begin
    top_d        = top_q;
    sub_d        = sub_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    col_d        = col_q;
    page_d       = page_q;
    data_ph_d    = data_ph_q;
    pending_d    = pending_q | frame_req;
    done_sync_d  = spi_send_done;
    done_prev_d  = done_sync_q;
    spi_send_d   = spi_send_q;
    spi_data_d   = spi_data_q;
    dc_d         = dc_q;
    oled_res_n_d = oled_res_n_q;
    init_done_d  = init_done_q;

    case (top_q)
      ST_RST_LOW: begin
        oled_res_n_d = 1'b0;
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          cnt_d        = '0;
          oled_res_n_d = 1'b1;
          top_d        = ST_RST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RST_WAIT: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          cnt_d = '0;
          top_d = ST_INIT;
          sub_d = B_ADDR;
          idx_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (pending_q) begin
          pending_d = 1'b0;
          top_d     = ST_FRAME;
          sub_d     = B_ADDR;
          idx_d     = '0;
          col_d     = '0;
          page_d    = '0;
          data_ph_d = 1'b0;
        end
      end
      default: begin
        // ADDR gives the framebuffer its read cycle before LOAD captures fb_data
        case (sub_q)
          B_ADDR: sub_d = B_LOAD;
          B_LOAD: begin
            spi_send_d = 1'b1;
            sub_d      = B_SEND;
            if (top_q == ST_INIT) begin
              spi_data_d = init_rom(idx_q);
              dc_d       = 1'b0;
            end else if (data_ph_q) begin
              spi_data_d = fb_data;
              dc_d       = 1'b1;
            end else begin
              spi_data_d = page_cmd_c;
              dc_d       = 1'b0;
            end
          end
          B_SEND: begin
            if (done_rise_c) begin
              spi_send_d = 1'b0;
              sub_d      = B_DRAIN;
            end
          end
          default: begin
            // spi_send is already low here, so spiMaster cannot retransmit
            if (!done_sync_q) begin
              sub_d = B_ADDR;
              if (top_q == ST_INIT) begin
                if (idx_q == IDX_W'(INIT_LEN - 1)) begin
                  idx_d       = '0;
                  init_done_d = 1'b1;
                  top_d       = ST_IDLE;
                end else begin
                  idx_d = idx_q + IDX_W'(1);
                end
              end else if (!data_ph_q) begin
                if (idx_q == IDX_W'(2)) begin
                  idx_d     = '0;
                  data_ph_d = 1'b1;
                end else begin
                  idx_d = idx_q + IDX_W'(1);
                end
              end else if (col_q == COL_W'(COLS - 1)) begin
                col_d     = '0;
                data_ph_d = 1'b0;
                if (page_q == PG_W'(PAGES - 1)) begin
                  page_d = '0;
                  top_d  = ST_IDLE;
                end else begin
                  page_d = page_q + PG_W'(1);
                end
              end else begin
                col_d = col_q + COL_W'(1);
              end
            end
          end
        endcase
      end
    endcase

    busy_d    = (top_d != ST_IDLE);
    fb_addr_d = {page_d, col_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_q        <= ST_RST_LOW;
      sub_q        <= B_ADDR;
      cnt_q        <= '0;
      idx_q        <= '0;
      col_q        <= '0;
      page_q       <= '0;
      data_ph_q    <= 1'b0;
      pending_q    <= 1'b0;
      done_sync_q  <= 1'b0;
      done_prev_q  <= 1'b0;
      spi_send_q   <= 1'b0;
      spi_data_q   <= 8'h00;
      dc_q         <= 1'b0;
      oled_res_n_q <= 1'b0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      fb_addr_q    <= '0;
    end else begin
      top_q        <= top_d;
      sub_q        <= sub_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      page_q       <= page_d;
      data_ph_q    <= data_ph_d;
      pending_q    <= pending_d;
      done_sync_q  <= done_sync_d;
      done_prev_q  <= done_prev_d;
      spi_send_q   <= spi_send_d;
      spi_data_q   <= spi_data_d;
      dc_q         <= dc_d;
      oled_res_n_q <= oled_res_n_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      fb_addr_q    <= fb_addr_d;
    end
  end

  assign fb_addr      = fb_addr_q;
  assign spi_data_out = spi_data_q;
  assign dc_in        = dc_q;
  assign spi_send     = spi_send_q;
  assign oled_res_n   = oled_res_n_q;
  assign init_done    = init_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Bench for oled_frame_sequencer: spiMaster responder, framebuffer RAM, and an
// expected byte stream built from the init list and page/column frame layout.
module tb_oled_frame_sequencer;

  localparam int unsigned N         = 8;
  localparam int unsigned FRAME_LEN = 8 * (3 + 128);

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_req;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       spi_send_done = 1'b0;
  logic [7:0] spi_data_out;
  logic       dc_in;
  logic       spi_send;
  logic       oled_res_n;
  logic       init_done;
  logic       busy;

  always #5 clk = ~clk;

  oled_frame_sequencer #(.RST_CYCLES(N), .PAGES(8), .COLS(128)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_req    (frame_req),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .spi_send_done(spi_send_done),
    .spi_data_out (spi_data_out),
    .dc_in        (dc_in),
    .spi_send     (spi_send),
    .oled_res_n   (oled_res_n),
    .init_done    (init_done),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] fb_mem [1024];
  always @(posedge clk) fb_data <= fb_mem[fb_addr];

  logic [7:0] init_seq [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                8'h8D, 8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

  // spiMaster stand-in: done rises 5 clk after it accepts a byte, held hold_cyc clk
  int unsigned hold_cyc = 4;
  int unsigned m_cnt;
  logic        m_busy = 1'b0;
  logic        prev_send = 1'b0;
  logic [8:0]  prev_payload;
  int unsigned rise_cnt = 0;
  int unsigned stab_err = 0;
  int unsigned send_in_done_err = 0;
  int unsigned idle_cyc = 0;
  logic [7:0]  log_byte [$];
  logic        log_dc [$];
  logic [7:0]  exp_byte [$];
  logic        exp_dc [$];

  always @(negedge clk) begin
    if (!reset_n) begin
      m_busy        = 1'b0;
      m_cnt         = 0;
      spi_send_done = 1'b0;
      prev_send     = 1'b0;
    end else begin
      if (!busy) idle_cyc++;
      if (spi_send && !prev_send) begin
        rise_cnt++;
        if (spi_send_done) send_in_done_err++;
      end
      if (spi_send && prev_send && ({dc_in, spi_data_out} != prev_payload)) stab_err++;
      prev_send    = spi_send;
      prev_payload = {dc_in, spi_data_out};
      if (!m_busy) begin
        if (spi_send) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          log_byte.push_back(spi_data_out);
          log_dc.push_back(dc_in);
        end
      end else begin
        m_cnt++;
        if (m_cnt == 5) spi_send_done = 1'b1;
        if (m_cnt == 5 + hold_cyc) begin
          spi_send_done = 1'b0;
          m_busy        = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input int i);
    if (i < log_byte.size()) return log_byte[i];
    return 8'hxx;
  endfunction

  task automatic expect_init();
    for (int i = 0; i < 25; i++) begin
      exp_byte.push_back(init_seq[i]);
      exp_dc.push_back(1'b0);
    end
  endtask

  task automatic expect_frame();
    for (int p = 0; p < 8; p++) begin
      exp_byte.push_back(8'hB0 + 8'(p)); exp_dc.push_back(1'b0);
      exp_byte.push_back(8'h00);         exp_dc.push_back(1'b0);
      exp_byte.push_back(8'h10);         exp_dc.push_back(1'b0);
      for (int c = 0; c < 128; c++) begin
        exp_byte.push_back(fb_mem[p * 128 + c]);
        exp_dc.push_back(1'b1);
      end
    end
  endtask

  task automatic clear_logs();
    log_byte.delete(); log_dc.delete();
    exp_byte.delete(); exp_dc.delete();
    rise_cnt = 0; stab_err = 0; send_in_done_err = 0; idle_cyc = 0;
  endtask

  task automatic compare_log(input string name);
    int first_bad = -1;
    check({name, " length"}, 32'(log_byte.size()), 32'(exp_byte.size()));
    for (int i = 0; i < exp_byte.size() && i < log_byte.size(); i++)
      if (first_bad < 0 && (log_byte[i] !== exp_byte[i] || log_dc[i] !== exp_dc[i])) first_bad = i;
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL %s stream: byte %0d got %02h dc=%0b expected %02h dc=%0b", name, first_bad,
               log_byte[first_bad], log_dc[first_bad], exp_byte[first_bad], exp_dc[first_bad]);
    end
  endtask

  task automatic wait_log(input int target, input int limit, input string name);
    int n = 0;
    while (log_byte.size() < target && n < limit) begin @(negedge clk); n++; end
    check({name, " reached"}, 32'(log_byte.size() >= target), 32'd1);
  endtask

  task automatic wait_init(input int limit, input string name);
    int n = 0;
    while (!init_done && n < limit) begin @(negedge clk); n++; end
    check({name, " init_done"}, 32'(init_done), 32'd1);
  endtask

  task automatic wait_busy(input logic level, input int limit, input string name);
    int n = 0;
    while (busy !== level && n < limit) begin @(negedge clk); n++; end
    check(name, 32'(busy), 32'(level));
  endtask

  task automatic pulse_req();
    @(negedge clk); frame_req = 1'b1;
    @(negedge clk); frame_req = 1'b0;
  endtask

  typedef struct {
    int unsigned cyc;
    logic        res_n;
    logic        send;
    logic        bsy;
    logic        idone;
    logic        dc;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int unsigned snap;
    vecs[0] = '{0,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{N - 1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{N,      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{N + 1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{2 * N,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{2*N+1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{2*N+2,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAE};

    reset_n = 1'b0; frame_req = 1'b0;
    for (int a = 0; a < 1024; a++) fb_mem[a] = 8'(a);
    repeat (3) @(negedge clk);
    check("reset oled_res_n", 32'(oled_res_n), 32'd0);
    check("reset spi_send", 32'(spi_send), 32'd0);
    check("reset spi_data_out", 32'(spi_data_out), 32'h00);
    check("reset dc_in", 32'(dc_in), 32'd0);
    check("reset fb_addr", 32'(fb_addr), 32'd0);
    check("reset init_done", 32'(init_done), 32'd0);
    check("reset busy", 32'(busy), 32'd1);

    // reset release timeline, sampled mid-cycle after posedge number cyc
    clear_logs();
    @(negedge clk); #1 reset_n = 1'b1;
    k = 0;
    for (int v = 0; v < 8; v++) begin
      while (k < vecs[v].cyc) begin @(posedge clk); k++; end
      #2;
      check($sformatf("vec%0d cyc%0d", v, vecs[v].cyc),
            32'({oled_res_n, spi_send, busy, init_done, dc_in, spi_data_out}),
            32'({vecs[v].res_n, vecs[v].send, vecs[v].bsy, vecs[v].idone, vecs[v].dc, vecs[v].data}));
    end
    wait_init(2000, "init1");
    @(negedge clk);
    check("init1 busy low", 32'(busy), 32'd0);
    expect_init();
    compare_log("init1");
    check("init1 handshakes", rise_cnt, 32'd25);

    // one frame with fb[a] = a[7:0]
    pulse_req();
    wait_busy(1'b1, 10, "frame1 busy rise");
    wait_busy(1'b0, 20000, "frame1 busy fall");
    expect_frame();
    compare_log("frame1");
    check("frame1 handshakes", rise_cnt, 32'(25 + FRAME_LEN));
    check("frame1 page0 first", 32'(get_byte(25)), 32'hB0);
    check("frame1 page7 first", 32'(get_byte(25 + 7 * 131)), 32'hB7);
    check("frame1 last data", 32'(get_byte(25 + FRAME_LEN - 1)), 32'hFF);
    check("frame1 payload stable", stab_err, 32'd0);

    // three requests around init plus one mid-frame collapse to two frames
    reset_n = 1'b0;
    for (int a = 0; a < 1024; a++) fb_mem[a] = 8'($urandom);
    @(negedge clk);
    clear_logs();
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_req();
    repeat (9) @(negedge clk);
    pulse_req();
    wait_log(3 + $urandom_range(0, 15), 2000, "multi init progress");
    pulse_req();
    wait_log(25 + 300 + $urandom_range(0, 400), 20000, "multi frame progress");
    pulse_req();
    wait_log(25 + 2 * FRAME_LEN, 40000, "multi end");
    snap = idle_cyc;
    check("multi idle gaps", snap, 32'd2);
    repeat (60) @(negedge clk);
    check("multi busy after", 32'(busy), 32'd0);
    expect_init(); expect_frame(); expect_frame();
    compare_log("multi");
    check("multi handshakes", rise_cnt, 32'(25 + 2 * FRAME_LEN));
    check("multi payload stable", stab_err, 32'd0);

    // reset mid-SEND at page 3 column 40 with a request pending
    clear_logs();
    pulse_req();
    wait_log(3 * 131 + 3 + 41, 8000, "midreset progress");
    check("midreset byte", 32'({log_dc[log_dc.size() - 1], log_byte[log_byte.size() - 1]}),
          32'({1'b1, fb_mem[3 * 128 + 40]}));
    check("midreset in send", 32'(spi_send), 32'd1);
    pulse_req();
    #1 reset_n = 1'b0;
    #1;
    check("midreset spi_send async", 32'(spi_send), 32'd0);
    check("midreset oled_res_n async", 32'(oled_res_n), 32'd0);
    check("midreset busy async", 32'(busy), 32'd1);

    // rerun of init with spi_send_done held high for 20 clk per byte
    hold_cyc = 20;
    @(negedge clk);
    clear_logs();
    #1 reset_n = 1'b1;
    wait_init(4000, "rerun");
    expect_init();
    compare_log("rerun");
    check("rerun handshakes", rise_cnt, 32'd25);
    check("rerun send during done", send_in_done_err, 32'd0);
    repeat (80) @(negedge clk);
    check("rerun pending cleared", 32'(log_byte.size()), 32'd25);
    check("rerun busy idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
